// File: rtl/wait_state_memory_pkg.sv
// Shared types and constants for the wait-state data memory.
package wait_state_memory_pkg;

  // Wait counter width; wait values are limited to 0..MAX_WAIT.
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  // Access FSM encoding, exposed on the debug state output.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // True when the implemented depth fits the address space.
  function automatic bit depth_ok(input int a_size, input int depth);
    return (depth >= 1) && (depth <= (1 << a_size));
  endfunction

  // True when a wait-state count fits the counter.
  function automatic bit wait_ok(input int w);
    return (w >= 0) && (w <= MAX_WAIT);
  endfunction

endpackage

// File: rtl/wait_state_memory_mem_array.sv
// DEPTH x D_SIZE storage: one synchronous write port, one synchronous
// read port with enable. No reset, so contents survive a reset of the FSM.
module wait_state_memory_mem_array #(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [A_SIZE-1:0] i_wr_addr,
  input  logic [D_SIZE-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [A_SIZE-1:0] i_rd_addr,
  output logic [D_SIZE-1:0] o_rd_data
);

  // Index width matches the implemented depth; callers only present
  // in-range addresses, so the upper address bits are always zero here.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D_SIZE-1:0] r_mem [DEPTH];
  logic [D_SIZE-1:0] r_rd_data;

  // Write port: store one word on an enabled edge.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
  end

  // Read port: capture one word on an enabled edge and hold it.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr[IDX_W-1:0]];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wait_state_memory.sv
// Data memory with programmable read/write wait states, range checking,
// a busy flag for stalling the core and per-access valid / err pulses.
//
// Handshake: a request (i_read xor i_write) is sampled only on an edge where
// the FSM is IDLE. o_busy rises the cycle after an accepted request and falls
// on the edge that commits the access (the FSM enters DONE). o_valid is a
// one-cycle pulse registered out of DONE, so it arrives WAIT+2 cycles after
// the request edge, with o_busy already low. o_err is a one-cycle pulse the
// cycle after a rejected request (both strobes, or address >= DEPTH).
// Requests seen in any state other than IDLE are ignored without err.
module wait_state_memory
  import wait_state_memory_pkg::*;
#(
  parameter int A_SIZE  = 10,
  parameter int D_SIZE  = 32,
  parameter int DEPTH   = 1024,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [A_SIZE-1:0] i_address,
  input  logic [D_SIZE-1:0] i_data_input,
  output logic [D_SIZE-1:0] o_data_output,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_err,
  output state_t            o_state
);

  // Elaboration-time parameter range checks.
  if (!depth_ok(A_SIZE, DEPTH)) begin : g_bad_depth
    $error("wait_state_memory: DEPTH out of range 1..2**A_SIZE");
  end
  if (!wait_ok(RD_WAIT) || !wait_ok(WR_WAIT)) begin : g_bad_wait
    $error("wait_state_memory: RD_WAIT/WR_WAIT out of range 0..15");
  end

  // One extra bit so DEPTH == 2**A_SIZE compares correctly.
  localparam logic [A_SIZE:0]  DEPTH_L = (A_SIZE+1)'(DEPTH);
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_WAIT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [A_SIZE-1:0]  r_addr;
  logic [D_SIZE-1:0]  r_data;
  logic [D_SIZE-1:0]  r_dout;
  logic               r_busy;
  logic               r_valid;
  logic               r_err;

  logic               w_in_range;
  logic               w_take_rd;
  logic               w_commit_wr;
  logic [D_SIZE-1:0]  w_rd_data;

  assign w_in_range  = {1'b0, i_address} < DEPTH_L;
  // The array read is launched on the accepting edge; its registered output
  // then holds the word until the commit edge, whatever RD_WAIT is.
  assign w_take_rd   = (r_state == S_IDLE) && i_read && !i_write && w_in_range;
  // The write happens only on the commit edge, so a reset while waiting
  // leaves memory untouched.
  assign w_commit_wr = (r_state == S_WR_WAIT) && (r_cnt == '0);

  wait_state_memory_mem_array #(
    .A_SIZE (A_SIZE),
    .D_SIZE (D_SIZE),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_commit_wr),
    .i_wr_addr (r_addr),
    .i_wr_data (r_data),
    .i_rd_en   (w_take_rd),
    .i_rd_addr (i_address),
    .o_rd_data (w_rd_data)
  );

  // Access FSM with wait counter, capture registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_read && i_write) begin
            r_err <= 1'b1;
          end else if (i_read || i_write) begin
            if (!w_in_range) begin
              r_err <= 1'b1;
            end else begin
              r_addr <= i_address;
              r_busy <= 1'b1;
              if (i_read) begin
                r_cnt   <= RD_CNT;
                r_state <= S_RD_WAIT;
              end else begin
                r_cnt   <= WR_CNT;
                r_data  <= i_data_input;
                r_state <= S_WR_WAIT;
              end
            end
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == '0) begin
            r_dout  <= w_rd_data;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_output = r_dout;
  assign o_busy        = r_busy;
  assign o_valid       = r_valid;
  assign o_err         = r_err;
  assign o_state       = r_state;

endmodule
